// File: rtl/traffic_timer.sv
// rtl/traffic_timer.sv - one-second tick divider and phase countdown feeding the traffic light FSM
// Optional feature macro: TRAFFIC_TIMER_BCD_EN (registered BCD copy of remaining_sec on remaining_bcd)
module traffic_timer #(
  parameter int CLK_PER_SEC       = 100,
  parameter int CNT_WIDTH         = 8,
  parameter int GREEN_SEC         = 10,
  parameter int YELLOW_SEC        = 3,
  parameter int RED_SEC           = 12,
  parameter int LIGHT_STATE_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
  output logic                         second_cnt_pre_last,
  output logic                         light_cnt_last,
  output logic [CNT_WIDTH-1:0]         remaining_sec,
  output logic [7:0]                   remaining_bcd
);

  localparam int SC_W     = $clog2(CLK_PER_SEC);
  localparam int DUR_MAX  = (1 << CNT_WIDTH) - 1;

  localparam logic [SC_W-1:0]      SC_LAST    = SC_W'(CLK_PER_SEC - 1);
  localparam logic [CNT_WIDTH-1:0] GREEN_LD   = CNT_WIDTH'(GREEN_SEC - 1);
  localparam logic [CNT_WIDTH-1:0] YELLOW_LD  = CNT_WIDTH'(YELLOW_SEC - 1);
  localparam logic [CNT_WIDTH-1:0] RED_LD     = CNT_WIDTH'(RED_SEC - 1);

  // Reject parameter sets the counters cannot represent.
  if (CLK_PER_SEC < 2) begin : g_bad_cps
    $error("traffic_timer: CLK_PER_SEC must be >= 2");
  end
  if (GREEN_SEC < 1 || GREEN_SEC > DUR_MAX ||
      YELLOW_SEC < 1 || YELLOW_SEC > DUR_MAX ||
      RED_SEC < 1 || RED_SEC > DUR_MAX) begin : g_bad_dur
    $error("traffic_timer: phase durations must lie in 1..2^CNT_WIDTH-1");
  end
  if (LIGHT_STATE_WIDTH != 3) begin : g_bad_lsw
    $error("traffic_timer: LIGHT_STATE_WIDTH must be 3 (green, yellow, red)");
  end

  logic [SC_W-1:0]      second_cnt;
  logic [CNT_WIDTH-1:0] light_cnt;

  assign second_cnt_pre_last = en & (second_cnt == SC_LAST);
  assign light_cnt_last      = (light_cnt == '0);

  // Clock-cycle counter within the current second; cleared whenever disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      second_cnt <= '0;
    end else if (!en || second_cnt == SC_LAST) begin
      second_cnt <= '0;
    end else begin
      second_cnt <= second_cnt + SC_W'(1);
    end
  end

  // Phase-second countdown: disable preloads green, reload beats decrement, stick at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      light_cnt <= GREEN_LD;
    end else if (!en) begin
      light_cnt <= GREEN_LD;
    end else if (light_cnt_init[2]) begin
      light_cnt <= RED_LD;
    end else if (light_cnt_init[1]) begin
      light_cnt <= YELLOW_LD;
    end else if (light_cnt_init[0]) begin
      light_cnt <= GREEN_LD;
    end else if (second_cnt_pre_last && light_cnt != '0) begin
      light_cnt <= light_cnt - CNT_WIDTH'(1);
    end
  end

  // Display copy of the seconds left, counting the current second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_sec <= '0;
    end else begin
      remaining_sec <= en ? light_cnt + CNT_WIDTH'(1) : '0;
    end
  end

`ifdef TRAFFIC_TIMER_BCD_EN
  // Two-digit BCD of a binary value, pinned at 99 for anything larger.
  function automatic logic [7:0] to_bcd(input logic [CNT_WIDTH-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    if (w >= 32'd99) begin
      return 8'h99;
    end
    return {4'(w / 32'd10), 4'(w % 32'd10)};
  endfunction

  // Registered BCD conversion, one cycle behind remaining_sec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_bcd <= 8'h00;
    end else begin
      remaining_bcd <= en ? to_bcd(remaining_sec) : 8'h00;
    end
  end
`else
  assign remaining_bcd = 8'h00;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// tb/tb_traffic_timer.sv - directed self-checking bench for traffic_timer
module tb_traffic_timer;

`ifdef TRAFFIC_TIMER_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, rst_b, en_b;
  logic [2:0] init, init_b;
  logic       pre_last, last, pre_last_b, last_b;
  logic [7:0] rem, bcd, rem_b, bcd_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  traffic_timer #(
    .CLK_PER_SEC(4), .CNT_WIDTH(8), .GREEN_SEC(3), .YELLOW_SEC(1), .RED_SEC(2), .LIGHT_STATE_WIDTH(3)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .light_cnt_init(init),
    .second_cnt_pre_last(pre_last), .light_cnt_last(last),
    .remaining_sec(rem), .remaining_bcd(bcd)
  );

  traffic_timer #(
    .CLK_PER_SEC(4), .CNT_WIDTH(8), .GREEN_SEC(3), .YELLOW_SEC(1), .RED_SEC(12), .LIGHT_STATE_WIDTH(3)
  ) u_dut_red12 (
    .clk(clk), .rst(rst_b), .en(en_b), .light_cnt_init(init_b),
    .second_cnt_pre_last(pre_last_b), .light_cnt_last(last_b),
    .remaining_sec(rem_b), .remaining_bcd(bcd_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; init = 3'b000;
    rst_b = 1'b1; en_b = 1'b0; init_b = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;

    // Run into the final green second so reset has something to clear.
    en = 1'b1;
    repeat (10) @(negedge clk);
    check("prerun_last", 32'(last), 32'd1);
    check("prerun_rem", 32'(rem), 32'd1);

    // Asynchronous reset asserted between edges.
    #2 rst = 1'b1;
    #1;
    check("rst_pre_last", 32'(pre_last), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    check("rst_hold_rem", 32'(rem), 32'd0);
    rst = 1'b0;

    // Cycle c = state after c enabled edges.
    for (int c = 0; c < 48; c++) begin
      en   = (c != 34);
      init = (c == 11 || c == 46) ? 3'b010 :
             (c == 15)            ? 3'b100 :
             (c == 23 || c == 27) ? 3'b001 : 3'b000;
      #1;
      case (c)
        0:  begin check("c0_rem", 32'(rem), 0); check("c0_pre", 32'(pre_last), 0); check("c0_last", 32'(last), 0); end
        1:  check("c1_rem", 32'(rem), 3);
        3:  check("c3_pre", 32'(pre_last), 1);
        4:  begin check("c4_pre", 32'(pre_last), 0); check("c4_rem", 32'(rem), 3); end
        5:  check("c5_rem", 32'(rem), 2);
        7:  begin check("c7_pre", 32'(pre_last), 1); check("c7_last", 32'(last), 0); end
        8:  begin check("c8_last", 32'(last), 1); check("c8_rem", 32'(rem), 2); end
        9:  check("c9_rem", 32'(rem), 1);
        11: begin check("c11_pre", 32'(pre_last), 1); check("c11_last", 32'(last), 1); end
        12: begin check("yel_last", 32'(last), 1); check("yel_pre0", 32'(pre_last), 0); check("c12_rem", 32'(rem), 1); end
        14: check("yel_pre2", 32'(pre_last), 0);
        15: begin check("yel_pre3", 32'(pre_last), 1); check("yel_last3", 32'(last), 1); end
        16: begin check("red_last", 32'(last), 0); check("c16_rem", 32'(rem), 1); end
        17: check("red_rem", 32'(rem), 2);
        18: check("red_bcd", 32'(bcd), BCD_ON ? 32'h02 : 32'h00);
        20: check("red_last_end", 32'(last), 1);
        23: begin check("c23_pre", 32'(pre_last), 1); check("c23_last", 32'(last), 1); end
        24: check("grn_last", 32'(last), 0);
        25: check("grn_rem", 32'(rem), 3);
        27: check("ovr_pre", 32'(pre_last), 1);
        29: check("ovr_rem", 32'(rem), 3);
        32: check("ovr_rem2", 32'(rem), 3);
        33: check("ovr_rem3", 32'(rem), 2);
        34: check("endrop_pre", 32'(pre_last), 0);
        35: begin check("endrop_rem", 32'(rem), 0); check("endrop_last", 32'(last), 0); check("endrop_pre_reen", 32'(pre_last), 0); end
        36: check("reen_rem", 32'(rem), 3);
        37: check("reen_pre2", 32'(pre_last), 0);
        38: check("reen_pre3", 32'(pre_last), 1);
        42: begin check("reen_last7", 32'(last), 0); check("reen_pre7", 32'(pre_last), 1); end
        43: check("reen_last8", 32'(last), 1);
        46: begin check("reen_pre11", 32'(pre_last), 1); check("reen_last11", 32'(last), 1); end
        default: ;
      endcase
      @(negedge clk);
    end

    // Twelve-second red on the second instance, checked through the BCD path.
    en_b = 1'b1; init_b = 3'b100;
    @(negedge clk);
    init_b = 3'b000;
    #1;
    check("r12_last", 32'(last_b), 0);
    check("r12_rem_pre", 32'(rem_b), 3);
    @(negedge clk);
    #1;
    check("r12_rem", 32'(rem_b), 12);
    check("r12_bcd_pre", 32'(bcd_b), BCD_ON ? 32'h03 : 32'h00);
    @(negedge clk);
    #1;
    check("r12_bcd", 32'(bcd_b), BCD_ON ? 32'h12 : 32'h00);
    check("r12_rem_hold", 32'(rem_b), 12);
    en_b = 1'b0;
    @(negedge clk);
    #1;
    check("r12_rem_off", 32'(rem_b), 0);
    @(negedge clk);
    #1;
    check("r12_bcd_off", 32'(bcd_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Timing datapath that feeds the traffic light FSM.
- Divides `clk` into one-second ticks and counts down the seconds left in the current light phase.
- Drives `second_cnt_pre_last` and `light_cnt_last` to the FSM.
- Reloads the phase duration from the FSM's one-hot `light_cnt_init` and exposes seconds-remaining for display.

Parameters:
- CLK_PER_SEC, 100, clk cycles per second; must be >= 2.
- CNT_WIDTH, 8, width of the phase-second counter and `remaining_sec`.
- GREEN_SEC, 10, green duration in seconds; range 1..2^CNT_WIDTH-1.
- YELLOW_SEC, 3, yellow duration in seconds; same range.
- RED_SEC, 12, red duration in seconds; same range.
- LIGHT_STATE_WIDTH, 3, width of `light_cnt_init`; bit 0 green, bit 1 yellow, bit 2 red.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; same signal as the FSM enable.
- light_cnt_init  in  LIGHT_STATE_WIDTH  one-hot phase reload request from the FSM.
- second_cnt_pre_last  out  1  high in the final clk cycle of each second.
- light_cnt_last  out  1  high while the current phase is in its final second.
- remaining_sec  out  CNT_WIDTH  seconds left in the current phase, including the current one.
- remaining_bcd  out  8  BCD tens:ones of `remaining_sec`; see Optional Feature.

Behaviour:
- Clocking: one clock, `clk`. `rst` is asynchronous and active-high; its assertion immediately forces the reset values below.
- Reset values:
  - `second_cnt` = 0, `light_cnt` = GREEN_SEC-1.
  - `second_cnt_pre_last` = 0; `light_cnt_last` = (GREEN_SEC==1).
  - `remaining_sec` = 0, `remaining_bcd` = 0.
- `second_cnt` width is $clog2(CLK_PER_SEC):
  - en=0: load 0.
  - en=1 and `second_cnt` == CLK_PER_SEC-1: wrap to 0.
  - Otherwise increment by 1.
- `second_cnt_pre_last` = en & (`second_cnt` == CLK_PER_SEC-1). Combinational from registers; no added latency.
- `light_cnt` (CNT_WIDTH bits), priority highest first:
  1. en=0: load GREEN_SEC-1, so the first green phase after enable is preloaded.
  2. `light_cnt_init` nonzero: load DURATION-1 of the set bit. If more than one bit is set (illegal), priority is red > yellow > green.
  3. `second_cnt_pre_last`=1 and `light_cnt` != 0: decrement.
  4. Otherwise: hold. `light_cnt` == 0 with no init holds at 0 and never wraps.
- `light_cnt_last` = (`light_cnt` == 0). Combinational from the register, not gated by en.
- FSM interaction:
  - The FSM advances when `light_cnt_last` & `second_cnt_pre_last` are both high, and raises `light_cnt_init` combinationally in that same cycle.
  - The reload therefore lands on the same edge as the second wrap.
  - Each phase lasts exactly DURATION*CLK_PER_SEC cycles.
- Enable timing: counting starts on the first edge with en=1. The FSM's one IDLE cycle overlaps `second_cnt`=0, so no compensation is needed.
- `remaining_sec` = en ? `light_cnt`+1 : 0. Registered; updates one cycle after `light_cnt` changes.
- en drop mid-phase: both counters reinitialise on the next edge.
- `rst` mid-phase: immediate return to the reset values; no partial second is carried over.
- Arithmetic is unsigned. Durations outside 1..2^CNT_WIDTH-1 are a parameter error, caught by an elaboration-time check.

Optional Feature:
- Macro: TRAFFIC_TIMER_BCD_EN.
- Defined:
  - `remaining_bcd[7:4]` = tens and `[3:0]` = ones of `remaining_sec`, using a registered binary-to-BCD conversion.
  - Values >= 99 saturate to 8'h99.
  - Latency is one cycle after `remaining_sec`.
  - Reset value 0; 0 while en=0.
- Undefined: `remaining_bcd` is tied to 8'h00 and no conversion logic is generated.

Test Plan:
1. Reset. Parameters CLK_PER_SEC=4, GREEN=3, YELLOW=1, RED=2. Assert rst mid-cycle -> outputs immediately: `second_cnt_pre_last`=0, `light_cnt_last`=0, `remaining_sec`=0, `remaining_bcd`=0.
2. Free-run countdown. en=1 from edge 0, `light_cnt_init`=0:
   - `second_cnt_pre_last` is high in cycles 3, 7, 11.
   - `light_cnt` goes 2→1 at edge 4 and 1→0 at edge 8; `light_cnt_last` is high from cycle 8.
   - Both signals are high together in cycle 11.
   - `remaining_sec` reads 3, 2, 1.
3. Phase reload. Drive `light_cnt_init`=3'b010 in cycle 11 -> `light_cnt`=0 and `light_cnt_last` stays 1, giving a 4-cycle yellow. Then `light_cnt_init`=3'b100 -> `light_cnt`=1 and `remaining_sec`=2.
4. Init overrides decrement. `light_cnt`=2 with `second_cnt_pre_last`=1 and `light_cnt_init`=3'b001 in the same cycle -> `light_cnt`=2 (GREEN-1) after the edge, not 1.
5. Enable drop. Drop en while `second_cnt`=2 and `light_cnt`=1 -> next edge: `second_cnt`=0, `light_cnt`=2, `remaining_sec`=0. Re-raise en -> full 12-cycle green.
6. BCD (TRAFFIC_TIMER_BCD_EN defined). RED_SEC=12 with red reload -> `remaining_sec`=12, then `remaining_bcd`=8'h12 one cycle later. Without the macro -> `remaining_bcd` stays 8'h00.
